// File: rtl/panel_pkg.sv
// -----------------------------------------------------------------------------
// panel_pkg
// Shared definitions for the operator-panel input conditioner:
//   - mode_state_e      : mode-selector FSM state encoding
//   - DB_CYCLES_DEFAULT : default debounce length in clock cycles
//   - is_run_state()    : true for the states in which the lathe may run
// -----------------------------------------------------------------------------
package panel_pkg;

    localparam int DB_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MANUAL    = 2'd1,
        AUTOMATIC = 2'd2,
        FAULT     = 2'd3
    } mode_state_e;

    // Run states are the only ones that accept a start request and the only
    // ones whose exit must force a stop.
    function automatic logic is_run_state(input mode_state_e st);
        return (st == MANUAL) || (st == AUTOMATIC);
    endfunction

endpackage

// File: rtl/panel_debounce.sv
// -----------------------------------------------------------------------------
// panel_debounce
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one
// raw panel contact. The debounced level flips only after the synchronized
// value has disagreed with it for DB_CYCLES consecutive cycles; a single
// agreeing cycle restarts the count. Raw-to-level latency is 2+DB_CYCLES.
//
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset (level and count cleared to 0)
//   raw   : raw contact, asynchronous to clk, may bounce
//   level : debounced level (flop output)
// -----------------------------------------------------------------------------
module panel_debounce
    import panel_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;

    // Two-stage synchronizer for the asynchronous contact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Disagreement counter; the level flips on the DB_CYCLES-th consecutive
    // disagreeing cycle (count runs 0..DB_CYCLES-1 then flips).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= 1'b0;
            cnt_r   <= '0;
        end else if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= ~level_r;
                cnt_r   <= '0;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign level = level_r;

endmodule

// File: rtl/panel_input_conditioner.sv
// -----------------------------------------------------------------------------
// panel_input_conditioner
// Conditions the lathe operator panel: every contact is synchronized and
// debounced, start/stop rising edges become one-cycle request pulses, and
// the AUTO/MAN selector drives an interlocked mode FSM with a fault state.
//
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   start_raw, stop_raw, sel0_raw,
//   auto_raw, man_raw                 : raw panel contacts (active-high)
//   start, stop                       : one-cycle request pulses
//   sel0                              : debounced selector level
//   AUTO, MAN                         : interlocked mode levels
//   fault                             : high while the selector is in conflict
//
// Timing: all registered outputs are loaded from the FSM's next state so that
// AUTO/MAN/fault, the forced stop and the start gate all line up with the
// cycle in which the new state becomes current.
// -----------------------------------------------------------------------------
module panel_input_conditioner
    import panel_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start_raw,
    input  logic stop_raw,
    input  logic sel0_raw,
    input  logic auto_raw,
    input  logic man_raw,
    output logic start,
    output logic stop,
    output logic sel0,
    output logic AUTO,
    output logic MAN,
    output logic fault
);

    logic        start_db_s;
    logic        stop_db_s;
    logic        sel0_db_s;
    logic        auto_db_s;
    logic        man_db_s;

    logic        start_prev_r;
    logic        stop_prev_r;
    logic        start_rise_s;
    logic        stop_rise_s;

    mode_state_e state_r;
    mode_state_e next_state_s;
    logic        forced_stop_s;
    logic        stop_next_s;
    logic        start_next_s;

    logic        start_r;
    logic        stop_r;
    logic        auto_r;
    logic        man_r;
    logic        fault_r;

    panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk(clk), .rst(rst), .raw(start_raw), .level(start_db_s)
    );
    panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
        .clk(clk), .rst(rst), .raw(stop_raw), .level(stop_db_s)
    );
    panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel0 (
        .clk(clk), .rst(rst), .raw(sel0_raw), .level(sel0_db_s)
    );
    panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_auto (
        .clk(clk), .rst(rst), .raw(auto_raw), .level(auto_db_s)
    );
    panel_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_man (
        .clk(clk), .rst(rst), .raw(man_raw), .level(man_db_s)
    );

    // Previous debounced button levels for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_prev_r <= 1'b0;
            stop_prev_r  <= 1'b0;
        end else begin
            start_prev_r <= start_db_s;
            stop_prev_r  <= stop_db_s;
        end
    end

    assign start_rise_s = start_db_s & ~start_prev_r;
    assign stop_rise_s  = stop_db_s  & ~stop_prev_r;

    // Mode FSM next-state logic; FAULT is sticky until both levels drop.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (auto_db_s && !man_db_s) begin
                    next_state_s = AUTOMATIC;
                end else if (man_db_s && !auto_db_s) begin
                    next_state_s = MANUAL;
                end else if (auto_db_s && man_db_s) begin
                    next_state_s = FAULT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MANUAL: begin
                if (auto_db_s) begin
                    next_state_s = FAULT;
                end else if (!man_db_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = MANUAL;
                end
            end
            AUTOMATIC: begin
                if (man_db_s) begin
                    next_state_s = FAULT;
                end else if (!auto_db_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = AUTOMATIC;
                end
            end
            FAULT: begin
                if (!auto_db_s && !man_db_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FAULT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Leaving a run state forces a stop; a coinciding button stop merges
    // into the same single pulse. Stop always wins over start, and start is
    // only honoured if the state being entered is a run state.
    assign forced_stop_s = is_run_state(state_r) && (next_state_s != state_r);
    assign stop_next_s   = stop_rise_s | forced_stop_s;
    assign start_next_s  = start_rise_s & ~stop_next_s & is_run_state(next_state_s);

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            start_r <= 1'b0;
            stop_r  <= 1'b0;
            auto_r  <= 1'b0;
            man_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            start_r <= start_next_s;
            stop_r  <= stop_next_s;
            auto_r  <= (next_state_s == AUTOMATIC);
            man_r   <= (next_state_s == MANUAL);
            fault_r <= (next_state_s == FAULT);
        end
    end

    assign start = start_r;
    assign stop  = stop_r;
    assign sel0  = sel0_db_s;
    assign AUTO  = auto_r;
    assign MAN   = man_r;
    assign fault = fault_r;

endmodule
